// File: rtl/cmu.sv
// cmu: cache management unit between the CPU data port and the cache array.
// Serves single load/store requests. On a miss it writes back a dirty victim
// line word by word, then refills the line from memory. The CPU is stalled
// until the request is re-presented in S_IDLE and hits.
module cmu #(
  parameter int unsigned TAG_BITS   = 23,
  parameter int unsigned INDEX_BITS = 5,
  parameter int unsigned WORD_BITS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_r,
  input  logic                en_w,
  input  logic [31:0]         addr_rw,
  input  logic [2:0]          u_b_h_w,
  input  logic [31:0]         data_w,
  output logic [31:0]         data_r,
  output logic                stall,
  output logic [31:0]         cache_addr,
  output logic                cache_load,
  output logic                cache_store,
  output logic                cache_replace,
  output logic                cache_invalid,
  output logic [2:0]          cache_u_b_h_w,
  output logic [31:0]         cache_din,
  input  logic                cache_hit,
  input  logic                cache_valid,
  input  logic                cache_dirty,
  input  logic [31:0]         cache_dout,
  input  logic [TAG_BITS-1:0] cache_tag,
  output logic                mem_cs_o,
  output logic                mem_we_o,
  output logic [31:0]         mem_addr_o,
  output logic [31:0]         mem_data_o,
  input  logic [31:0]         mem_data_i,
  input  logic                mem_ack_i
);

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_BACK,
    S_BACK,
    S_FILL,
    S_WAIT
  } state_t;

  state_t                state, state_nx;
  logic [WORD_BITS-1:0]  cnt, cnt_nx;
  logic [TAG_BITS-1:0]   victim_tag, victim_tag_nx;
  logic [INDEX_BITS-1:0] index_q, index_nx;
  logic [31:0]           wb_buf, wb_buf_nx;

  logic [TAG_BITS-1:0]   cpu_tag;
  logic [INDEX_BITS-1:0] cpu_index;
  logic [31:0]           victim_addr;
  logic [31:0]           fill_addr;
  logic                  last_word;
  logic                  req;

  assign cpu_tag     = addr_rw[31 -: TAG_BITS];
  assign cpu_index   = addr_rw[2 + WORD_BITS +: INDEX_BITS];
  assign victim_addr = {victim_tag, index_q, cnt, 2'b00};
  // The CPU holds its request while stalled, so the fill tag comes straight
  // from the live address; only the index is latched alongside the victim tag.
  assign fill_addr   = {cpu_tag, index_q, cnt, 2'b00};
  assign last_word   = (cnt == '1);
  assign req         = en_r | en_w;

  assign data_r        = cache_dout;
  assign cache_invalid = 1'b0;
  assign stall         = req & ~((state == S_IDLE) & cache_hit);

  // State and line-transfer registers; synchronous reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      victim_tag <= '0;
      index_q    <= '0;
      wb_buf     <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      victim_tag <= victim_tag_nx;
      index_q    <= index_nx;
      wb_buf     <= wb_buf_nx;
    end
  end

  // Next-state logic plus cache strobe and memory port decodes.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    victim_tag_nx = victim_tag;
    index_nx      = index_q;
    wb_buf_nx     = wb_buf;
    cache_addr    = addr_rw;
    cache_load    = 1'b0;
    cache_store   = 1'b0;
    cache_replace = 1'b0;
    cache_u_b_h_w = u_b_h_w;
    cache_din     = data_w;
    mem_cs_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;

    unique case (state)
      S_IDLE: begin
        if (en_w) begin
          cache_store = 1'b1;
        end else if (en_r) begin
          cache_load = 1'b1;
        end
        if (req && !cache_hit) begin
          victim_tag_nx = cache_tag;
          index_nx      = cpu_index;
          cnt_nx        = '0;
          state_nx      = (cache_valid && cache_dirty) ? S_PRE_BACK : S_FILL;
        end
      end

      S_PRE_BACK: begin
        cache_load    = 1'b1;
        cache_addr    = victim_addr;
        cache_u_b_h_w = SIZE_WORD;
        wb_buf_nx     = cache_dout;
        state_nx      = S_BACK;
      end

      S_BACK: begin
        mem_cs_o   = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = victim_addr;
        mem_data_o = wb_buf;
        if (mem_ack_i) begin
          if (last_word) begin
            cnt_nx   = '0;
            state_nx = S_FILL;
          end else begin
            cnt_nx   = cnt + WORD_BITS'(1);
            state_nx = S_PRE_BACK;
          end
        end
      end

      S_FILL: begin
        mem_cs_o   = 1'b1;
        mem_addr_o = fill_addr;
        if (mem_ack_i) begin
          cache_replace = 1'b1;
          cache_din     = mem_data_i;
          cache_addr    = fill_addr;
          cache_u_b_h_w = SIZE_WORD;
          if (last_word) begin
            state_nx = S_WAIT;
          end else begin
            cnt_nx = cnt + WORD_BITS'(1);
          end
        end
      end

      S_WAIT: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cmu.sv
// tb_cmu: directed bench for cmu. The cache and memory are modelled by the
// bench: cache_dout and mem_data_i are fixed functions of the address presented.
module tb_cmu;

  localparam logic [31:0] K_C = 32'hC0DE_0000;
  localparam logic [31:0] K_M = 32'h3EE7_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_r, en_w;
  logic [31:0] addr_rw;
  logic [2:0]  u_b_h_w;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic        stall;
  logic [31:0] cache_addr;
  logic        cache_load, cache_store, cache_replace, cache_invalid;
  logic [2:0]  cache_u_b_h_w;
  logic [31:0] cache_din;
  logic        cache_hit, cache_valid, cache_dirty;
  logic [31:0] cache_dout;
  logic [22:0] cache_tag;
  logic        mem_cs_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_ack_i;

  int tests  = 0;
  int failed = 0;

  assign cache_dout = cache_addr ^ K_C;
  assign mem_data_i = mem_addr_o ^ K_M;

  always #5 clk = ~clk;

  cmu #(.TAG_BITS(23), .INDEX_BITS(5), .WORD_BITS(2)) dut (
    .clk(clk), .rst(rst), .en_r(en_r), .en_w(en_w), .addr_rw(addr_rw),
    .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(data_r), .stall(stall),
    .cache_addr(cache_addr), .cache_load(cache_load), .cache_store(cache_store),
    .cache_replace(cache_replace), .cache_invalid(cache_invalid),
    .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din),
    .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
    .cache_dout(cache_dout), .cache_tag(cache_tag),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en_r;
    logic        en_w;
    logic [31:0] addr;
    logic [2:0]  ubhw;
    logic [31:0] wdata;
    logic        hit;
    logic        e_stall;
    logic        e_load;
    logic        e_store;
  } vec_t;

  vec_t vecs[7];

  // Runs one miss: memory acks each word on the 2nd cycle of mem_cs_o; the
  // cache reports a hit once four replace pulses have been seen.
  // abort_after >= 0 asserts rst during the write-back of word abort_after.
  task automatic run_miss(input logic [31:0] a, input logic dirty, input logic [22:0] vtag,
                          input int abort_after, input int exp_cycles);
    logic [31:0] exp_addr[$];
    logic        exp_we[$];
    logic [31:0] rd_addr[4];
    int n_tr, n_rep, wcnt, cyc;
    logic done, aborted;
    for (int i = 0; i < 4; i++) begin
      if (dirty) begin
        exp_addr.push_back({vtag, a[8:4], 4'b0000} + 32'(4 * i));
        exp_we.push_back(1'b1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr[i] = {a[31:4], 4'b0000} + 32'(4 * i);
      exp_addr.push_back(rd_addr[i]);
      exp_we.push_back(1'b0);
    end
    @(negedge clk);
    en_r = 1'b1; en_w = 1'b0; addr_rw = a; u_b_h_w = 3'b010;
    cache_valid = 1'b1; cache_dirty = dirty; cache_tag = vtag;
    n_tr = 0; n_rep = 0; wcnt = 0; cyc = 0; done = 1'b0; aborted = 1'b0;
    while (!done && cyc < 200) begin
      if (mem_cs_o) begin
        wcnt++;
        mem_ack_i = (wcnt >= 2);
        if (mem_ack_i) wcnt = 0;
      end else begin
        wcnt = 0;
        mem_ack_i = 1'b0;
      end
      cache_hit = (n_rep == 4);
      #1;
      chk("replace_only_on_read_ack", cache_replace, mem_cs_o & mem_ack_i & ~mem_we_o);
      if (mem_cs_o && mem_ack_i) begin
        if (n_tr < exp_addr.size()) begin
          chk("mem_addr", mem_addr_o, exp_addr[n_tr]);
          chk("mem_we", mem_we_o, exp_we[n_tr]);
          if (exp_we[n_tr]) chk("wb_data", mem_data_o, exp_addr[n_tr] ^ K_C);
        end else begin
          chk("txn_overflow", n_tr, exp_addr.size() - 1);
        end
        n_tr++;
      end
      if (cache_replace) begin
        if (n_rep < 4) begin
          chk("rep_addr", cache_addr, rd_addr[n_rep]);
          chk("rep_din", cache_din, rd_addr[n_rep] ^ K_M);
          chk("rep_size", cache_u_b_h_w, 3'b010);
        end else begin
          chk("rep_overflow", n_rep, 3);
        end
        n_rep++;
      end
      if (abort_after >= 0 && n_tr == abort_after && mem_cs_o && mem_we_o && !mem_ack_i) begin
        rst = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        cache_hit = 1'b0;
        #1;
        chk("abort_mem_cs", mem_cs_o, 1'b0);
        chk("abort_mem_we", mem_we_o, 1'b0);
        chk("abort_mem_addr", mem_addr_o, 32'h0);
        chk("abort_stall", stall, 1'b1);
        aborted = 1'b1;
        done = 1'b1;
      end else if (!stall) begin
        done = 1'b1;
      end else begin
        cyc++;
        @(negedge clk);
      end
    end
    chk("miss_completed", done, 1'b1);
    if (!aborted && done) begin
      chk("stall_cycles", cyc, exp_cycles);
      chk("txn_count", n_tr, exp_addr.size());
      chk("replace_count", n_rep, 4);
      chk("final_load", cache_load, 1'b1);
      chk("final_data_r", data_r, a ^ K_C);
    end
    mem_ack_i = 1'b0;
    en_r = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en_r = 1'b0; en_w = 1'b0; addr_rw = '0; u_b_h_w = '0; data_w = '0;
    cache_hit = 1'b0; cache_valid = 1'b0; cache_dirty = 1'b0; cache_tag = '0; mem_ack_i = 1'b0;

    // Reset: two cycles high, then idle with no request.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_cs", mem_cs_o, 1'b0);
    chk("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_data", mem_data_o, 32'h0);
    chk("rst_strobes", {cache_load, cache_store, cache_replace, cache_invalid}, 4'b0000);

    // S_IDLE decode table; rst is held so miss rows do not leave S_IDLE.
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 3'b000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_1010, 3'b100, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_1014, 3'b001, 32'h1111_2222, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0040, 3'b010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0044, 3'b010, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_3008, 3'b000, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_300C, 3'b101, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      en_r = vecs[i].en_r; en_w = vecs[i].en_w; addr_rw = vecs[i].addr;
      u_b_h_w = vecs[i].ubhw; data_w = vecs[i].wdata; cache_hit = vecs[i].hit;
      #1;
      chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
      chk($sformatf("v%0d_load", i), cache_load, vecs[i].e_load);
      chk($sformatf("v%0d_store", i), cache_store, vecs[i].e_store);
      chk($sformatf("v%0d_replace", i), cache_replace, 1'b0);
      chk($sformatf("v%0d_invalid", i), cache_invalid, 1'b0);
      chk($sformatf("v%0d_addr", i), cache_addr, vecs[i].addr);
      chk($sformatf("v%0d_size", i), cache_u_b_h_w, vecs[i].ubhw);
      chk($sformatf("v%0d_mem_cs", i), mem_cs_o, 1'b0);
      if (vecs[i].en_w) chk($sformatf("v%0d_din", i), cache_din, vecs[i].wdata);
      chk($sformatf("v%0d_data_r", i), data_r, vecs[i].addr ^ K_C);
    end
    @(negedge clk);
    en_r = 1'b0; en_w = 1'b0; cache_hit = 1'b0;
    rst = 1'b0;

    // Clean miss: 1 miss cycle + 4 x 2 fill cycles + 1 wait cycle.
    run_miss(32'h0000_1010, 1'b0, 23'h000123, -1, 10);
    // Dirty miss: adds 4 x (1 pre-back + 2 memory) cycles.
    run_miss(32'h0000_2020, 1'b1, 23'h000005, -1, 22);

    // Store hit after a completed miss: no memory activity, no stall.
    @(negedge clk);
    en_w = 1'b1; addr_rw = 32'h0000_2024; data_w = 32'hDEAD_BEEF; cache_hit = 1'b1;
    #1;
    chk("st_store", cache_store, 1'b1);
    chk("st_stall", stall, 1'b0);
    chk("st_din", cache_din, 32'hDEAD_BEEF);
    chk("st_mem_cs", mem_cs_o, 1'b0);
    @(negedge clk);
    en_w = 1'b0; cache_hit = 1'b0;

    // Reset during the write-back of the third word.
    run_miss(32'h0000_4040, 1'b1, 23'h000077, 2, 0);
    @(negedge clk);
    rst = 1'b0; en_r = 1'b1; addr_rw = 32'h0000_4040; cache_hit = 1'b1;
    #1;
    chk("post_abort_stall", stall, 1'b0);
    chk("post_abort_load", cache_load, 1'b1);
    chk("post_abort_mem_cs", mem_cs_o, 1'b0);
    @(negedge clk);
    en_r = 1'b0; cache_hit = 1'b0;
    #1;
    chk("post_abort_idle_stall", stall, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
